// File: rtl/lane_tracker_pkg.sv
// Shared types and helpers for the lane tracker.
//   trk_state_e : tracker FSM states, encoded as reported on trk_state
//   lane_rec_t  : one lane record {num_lanes, cur_lane, left, right}
//   lane_plausible() : sanity filter applied to every incoming frame
package lane_tracker_pkg;

  localparam int unsigned LANE_W        = 4;
  localparam int unsigned IMG_WIDTH_DEF = 416;
  // Boundary width; IMG_WIDTH-1 must fit in BND_W-1 bits so signed maths has headroom.
  localparam int unsigned BND_W         = $clog2(IMG_WIDTH_DEF) + 1;

  typedef enum logic [1:0] {
    StSearch  = 2'd0,
    StConfirm = 2'd1,
    StTrack   = 2'd2,
    StHold    = 2'd3
  } trk_state_e;

  typedef struct packed {
    logic [LANE_W-1:0] num_lanes;
    logic [LANE_W-1:0] cur_lane;
    logic [BND_W-1:0]  left;
    logic [BND_W-1:0]  right;
  } lane_rec_t;

  function automatic logic lane_plausible(lane_rec_t r, int unsigned img_w);
    return (r.num_lanes != '0) && (r.cur_lane != '0) && (r.cur_lane <= r.num_lanes) &&
           (r.left < r.right) && (32'(r.right) < img_w);
  endfunction

endpackage

// File: rtl/lane_tracker_geom_calc.sv
// Output record stage: on load_i, captures the committed lane record and the geometry derived
// from its boundaries (centre, signed offset from the car centre, departure flags).
//   clk, rst        : clock, synchronous active-high reset
//   load_i          : capture rec_i / lane_chg_i this cycle
//   rec_i           : committed lane record to publish
//   lane_chg_i      : lane-change code accompanying this record
//   *_o             : registered record fields
module lane_tracker_geom_calc
  import lane_tracker_pkg::*;
#(
  parameter int unsigned IMG_WIDTH     = IMG_WIDTH_DEF,
  parameter int unsigned DEPART_MARGIN = 20
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_i,
  input  lane_rec_t               rec_i,
  input  logic [1:0]              lane_chg_i,
  output logic [LANE_W-1:0]       num_lanes_o,
  output logic [LANE_W-1:0]       cur_lane_o,
  output logic [BND_W-1:0]        center_o,
  output logic signed [BND_W:0]   offset_o,
  output logic                    depart_l_o,
  output logic                    depart_r_o,
  output logic [1:0]              lane_chg_o
);

  localparam int unsigned BW = BND_W;

  logic [BW-1:0]        center;
  logic signed [BW+1:0] half_s, margin_s, center_s, left_s, right_s, offset_s;
  logic                 depart_l, depart_r;

  always_comb begin
    // Sum in BW+1 bits so the halving never loses the carry.
    center   = BW'(({1'b0, rec_i.left} + {1'b0, rec_i.right}) >> 1);
    half_s   = (BW+2)'(IMG_WIDTH / 2);
    margin_s = (BW+2)'(DEPART_MARGIN);
    center_s = {2'b00, center};
    left_s   = {2'b00, rec_i.left};
    right_s  = {2'b00, rec_i.right};
    offset_s = center_s - half_s;
    depart_l = (half_s - left_s) < margin_s;
    depart_r = (right_s - half_s) < margin_s;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_lanes_o <= '0;
      cur_lane_o  <= '0;
      center_o    <= '0;
      offset_o    <= '0;
      depart_l_o  <= 1'b0;
      depart_r_o  <= 1'b0;
      lane_chg_o  <= 2'b00;
    end else if (load_i) begin
      num_lanes_o <= rec_i.num_lanes;
      cur_lane_o  <= rec_i.cur_lane;
      center_o    <= center;
      offset_o    <= (BW+1)'(offset_s);
      depart_l_o  <= depart_l;
      depart_r_o  <= depart_r;
      lane_chg_o  <= lane_chg_i;
    end
  end

endmodule

// File: rtl/lane_tracker.sv
// Temporal lane tracker: debounces per-frame lane records, coasts through bad frames, detects
// lane changes and publishes records over a valid/ready handshake.
//   clk, rst                  : clock, synchronous active-high reset
//   dec_*                     : incoming frame record, one per dec_valid cycle
//   trk_valid / trk_ready     : output handshake; record held while valid && !ready
//   trk_*                     : committed record, geometry, lane-change code
//   trk_state                 : current FSM state
//   trk_overrun               : sticky, an unconsumed record was overwritten
module lane_tracker
  import lane_tracker_pkg::*;
#(
  parameter int unsigned IMG_WIDTH      = IMG_WIDTH_DEF,
  parameter int unsigned CONFIRM_FRAMES = 3,
  parameter int unsigned LOST_FRAMES    = 8,
  parameter int unsigned DEPART_MARGIN  = 20
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dec_valid,
  input  logic [LANE_W-1:0]     dec_num_lanes,
  input  logic [LANE_W-1:0]     dec_cur_lane,
  input  logic [BND_W-1:0]      dec_left_bnd,
  input  logic [BND_W-1:0]      dec_right_bnd,
  output logic                  trk_valid,
  input  logic                  trk_ready,
  output logic [LANE_W-1:0]     trk_num_lanes,
  output logic [LANE_W-1:0]     trk_cur_lane,
  output logic [BND_W-1:0]      trk_center,
  output logic signed [BND_W:0] trk_offset,
  output logic                  trk_depart_l,
  output logic                  trk_depart_r,
  output logic [1:0]            trk_lane_chg,
  output logic [1:0]            trk_state,
  output logic                  trk_overrun
);

  localparam int unsigned CW = $clog2(CONFIRM_FRAMES + 1);
  localparam int unsigned MW = $clog2(LOST_FRAMES + 1);

  trk_state_e        state_q, state_d;
  logic [LANE_W-1:0] cand_num_q, cand_num_d, cand_cur_q, cand_cur_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  lane_rec_t         com_q, com_d;
  logic [LANE_W-1:0] pend_lane_q, pend_lane_d;
  logic [CW-1:0]     pend_cnt_q, pend_cnt_d;
  logic [MW-1:0]     miss_q, miss_d;
  logic              valid_q, valid_d, overrun_q, overrun_d;

  lane_rec_t   frame;
  logic        plaus, match_cand, match_com, adjacent, start_cand, load;
  logic [1:0]  chg_d;
  logic [31:0] pend_next;

  always_comb begin
    frame      = '{num_lanes: dec_num_lanes, cur_lane: dec_cur_lane,
                   left: dec_left_bnd, right: dec_right_bnd};
    plaus      = lane_plausible(frame, IMG_WIDTH);
    match_cand = plaus && (frame.num_lanes == cand_num_q) && (frame.cur_lane == cand_cur_q);
    match_com  = plaus && (frame.num_lanes == com_q.num_lanes) &&
                 (frame.cur_lane == com_q.cur_lane);
    adjacent   = plaus && (frame.num_lanes == com_q.num_lanes) &&
                 ((frame.cur_lane == com_q.cur_lane + 4'd1) ||
                  (frame.cur_lane == com_q.cur_lane - 4'd1));
  end

  always_comb begin
    state_d     = state_q;
    cand_num_d  = cand_num_q;
    cand_cur_d  = cand_cur_q;
    cnt_d       = cnt_q;
    com_d       = com_q;
    pend_lane_d = pend_lane_q;
    pend_cnt_d  = pend_cnt_q;
    miss_d      = miss_q;
    chg_d       = 2'b00;
    start_cand  = 1'b0;
    pend_next   = 32'd1;
    if (dec_valid) begin
      unique case (state_q)
        StSearch: begin
          if (plaus) start_cand = 1'b1;
        end
        StConfirm: begin
          if (match_cand) begin
            if (32'(cnt_q) + 32'd1 >= CONFIRM_FRAMES) begin
              com_d      = frame;
              cnt_d      = CW'(CONFIRM_FRAMES);
              pend_cnt_d = '0;
              miss_d     = '0;
              state_d    = StTrack;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else if (plaus) begin
            start_cand = 1'b1;
          end else begin
            cnt_d   = '0;
            state_d = StSearch;
          end
        end
        StTrack: begin
          if (match_com) begin
            com_d      = frame;
            pend_cnt_d = '0;
          end else if (adjacent) begin
            // A new target lane restarts the debounce.
            if ((pend_cnt_q != '0) && (pend_lane_q == frame.cur_lane)) begin
              pend_next = 32'(pend_cnt_q) + 32'd1;
            end
            if (pend_next >= CONFIRM_FRAMES) begin
              chg_d      = (frame.cur_lane > com_q.cur_lane) ? 2'b10 : 2'b01;
              com_d      = frame;
              pend_cnt_d = '0;
            end else begin
              pend_cnt_d  = CW'(pend_next);
              pend_lane_d = frame.cur_lane;
            end
          end else if (plaus) begin
            start_cand = 1'b1;
          end else begin
            pend_cnt_d = '0;
            if (LOST_FRAMES == 1) begin
              com_d   = '0;
              miss_d  = '0;
              cnt_d   = '0;
              state_d = StSearch;
            end else begin
              miss_d  = MW'(1);
              state_d = StHold;
            end
          end
        end
        StHold: begin
          if (match_com) begin
            com_d   = frame;
            miss_d  = '0;
            state_d = StTrack;
          end else if (plaus) begin
            start_cand = 1'b1;
          end else if (32'(miss_q) + 32'd1 >= LOST_FRAMES) begin
            com_d   = '0;
            miss_d  = '0;
            cnt_d   = '0;
            state_d = StSearch;
          end else begin
            miss_d = miss_q + 1'b1;
          end
        end
        default: ;
      endcase
      if (start_cand) begin
        cand_num_d = frame.num_lanes;
        cand_cur_d = frame.cur_lane;
        cnt_d      = CW'(1);
        pend_cnt_d = '0;
        miss_d     = '0;
        if (CONFIRM_FRAMES == 1) begin
          com_d   = frame;
          state_d = StTrack;
        end else begin
          state_d = StConfirm;
        end
      end
    end
  end

  // A record is published for every frame that leaves the tracker committed (TRACK or HOLD).
  always_comb begin
    load      = dec_valid && ((state_d == StTrack) || (state_d == StHold));
    valid_d   = load ? 1'b1 : (valid_q && !trk_ready ? 1'b1 : 1'b0);
    overrun_d = overrun_q | (load & valid_q & ~trk_ready);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StSearch;
      cand_num_q  <= '0;
      cand_cur_q  <= '0;
      cnt_q       <= '0;
      com_q       <= '0;
      pend_lane_q <= '0;
      pend_cnt_q  <= '0;
      miss_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_num_q  <= cand_num_d;
      cand_cur_q  <= cand_cur_d;
      cnt_q       <= cnt_d;
      com_q       <= com_d;
      pend_lane_q <= pend_lane_d;
      pend_cnt_q  <= pend_cnt_d;
      miss_q      <= miss_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  lane_tracker_geom_calc #(
    .IMG_WIDTH     (IMG_WIDTH),
    .DEPART_MARGIN (DEPART_MARGIN)
  ) u_geom (
    .clk         (clk),
    .rst         (rst),
    .load_i      (load),
    .rec_i       (com_d),
    .lane_chg_i  (chg_d),
    .num_lanes_o (trk_num_lanes),
    .cur_lane_o  (trk_cur_lane),
    .center_o    (trk_center),
    .offset_o    (trk_offset),
    .depart_l_o  (trk_depart_l),
    .depart_r_o  (trk_depart_r),
    .lane_chg_o  (trk_lane_chg)
  );

  assign trk_valid   = valid_q;
  assign trk_overrun = overrun_q;
  assign trk_state   = state_q;

endmodule

// File: tb/tb_lane_tracker.sv
module tb_lane_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        dec_valid = 1'b0;
  logic [3:0]  dec_num_lanes = '0;
  logic [3:0]  dec_cur_lane = '0;
  logic [9:0]  dec_left_bnd = '0;
  logic [9:0]  dec_right_bnd = '0;
  logic        trk_ready = 1'b1;
  logic        trk_valid;
  logic [3:0]  trk_num_lanes, trk_cur_lane;
  logic [9:0]  trk_center;
  logic signed [10:0] trk_offset;
  logic        trk_depart_l, trk_depart_r;
  logic [1:0]  trk_lane_chg, trk_state;
  logic        trk_overrun;

  int checks = 0;
  int errors = 0;

  lane_tracker dut (
    .clk           (clk),
    .rst           (rst),
    .dec_valid     (dec_valid),
    .dec_num_lanes (dec_num_lanes),
    .dec_cur_lane  (dec_cur_lane),
    .dec_left_bnd  (dec_left_bnd),
    .dec_right_bnd (dec_right_bnd),
    .trk_valid     (trk_valid),
    .trk_ready     (trk_ready),
    .trk_num_lanes (trk_num_lanes),
    .trk_cur_lane  (trk_cur_lane),
    .trk_center    (trk_center),
    .trk_offset    (trk_offset),
    .trk_depart_l  (trk_depart_l),
    .trk_depart_r  (trk_depart_r),
    .trk_lane_chg  (trk_lane_chg),
    .trk_state     (trk_state),
    .trk_overrun   (trk_overrun)
  );

  always #5 clk = ~clk;

  // Observed record packed as {num, cur, center, offset, depart_l, depart_r, lane_chg}.
  function automatic logic [32:0] rec_now();
    return {trk_num_lanes, trk_cur_lane, trk_center, trk_offset, trk_depart_l, trk_depart_r,
            trk_lane_chg};
  endfunction

  // Called at a negedge; returns at the next negedge, one posedge after the frame was seen.
  task automatic send(input logic [3:0] n, input logic [3:0] c, input logic [9:0] l,
                      input logic [9:0] r);
    dec_valid = 1'b1; dec_num_lanes = n; dec_cur_lane = c; dec_left_bnd = l; dec_right_bnd = r;
    @(negedge clk);
    dec_valid = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (trk_state !== 2'd0) begin errors++;
      $display("FAIL reset_state got %0d want 0", trk_state); end
    checks++; if (trk_valid !== 1'b0 || trk_overrun !== 1'b0) begin errors++;
      $display("FAIL reset_flags got v=%b o=%b want 0 0", trk_valid, trk_overrun); end
    checks++; if (rec_now() !== 33'd0) begin errors++;
      $display("FAIL reset_record got %h want 0", rec_now()); end
  endtask

  task automatic test_confirm();
    trk_ready = 1'b1;
    send(4'd3, 4'd2, 10'd150, 10'd260);
    checks++; if (trk_state !== 2'd1 || trk_valid !== 1'b0) begin errors++;
      $display("FAIL confirm_f1 got st=%0d v=%b want 1 0", trk_state, trk_valid); end
    send(4'd3, 4'd2, 10'd150, 10'd260);
    checks++; if (trk_state !== 2'd1 || trk_valid !== 1'b0) begin errors++;
      $display("FAIL confirm_f2 got st=%0d v=%b want 1 0", trk_state, trk_valid); end
    send(4'd3, 4'd2, 10'd150, 10'd260);
    checks++; if (trk_state !== 2'd2 || trk_valid !== 1'b1) begin errors++;
      $display("FAIL confirm_f3 got st=%0d v=%b want 2 1", trk_state, trk_valid); end
    checks++; if (rec_now() !== {4'd3, 4'd2, 10'd205, -11'sd3, 1'b0, 1'b0, 2'b00}) begin errors++;
      $display("FAIL confirm_rec got c=%0d ctr=%0d off=%0d dl=%b dr=%b chg=%b want 2 205 -3 0 0 00",
               trk_cur_lane, trk_center, trk_offset, trk_depart_l, trk_depart_r, trk_lane_chg); end
  endtask

  task automatic test_lane_change();
    for (int i = 0; i < 2; i++) begin
      send(4'd3, 4'd3, 10'd260, 10'd380);
      checks++; if (rec_now() !== {4'd3, 4'd2, 10'd205, -11'sd3, 1'b0, 1'b0, 2'b00} ||
                    trk_state !== 2'd2) begin errors++;
        $display("FAIL chg_pending%0d got c=%0d ctr=%0d chg=%b st=%0d want 2 205 00 2", i,
                 trk_cur_lane, trk_center, trk_lane_chg, trk_state); end
    end
    send(4'd3, 4'd3, 10'd260, 10'd380);
    checks++; if (rec_now() !== {4'd3, 4'd3, 10'd320, 11'sd112, 1'b1, 1'b0, 2'b10}) begin errors++;
      $display("FAIL chg_commit got c=%0d ctr=%0d off=%0d dl=%b dr=%b chg=%b want 3 320 112 1 0 10",
               trk_cur_lane, trk_center, trk_offset, trk_depart_l, trk_depart_r, trk_lane_chg); end
    send(4'd3, 4'd3, 10'd260, 10'd380);
    checks++; if (trk_lane_chg !== 2'b00 || trk_cur_lane !== 4'd3) begin errors++;
      $display("FAIL chg_clear got chg=%b c=%0d want 00 3", trk_lane_chg, trk_cur_lane); end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 2; i++) begin
      send(4'd0, 4'd0, 10'd0, 10'd0);
      checks++; if (trk_state !== 2'd3 || trk_valid !== 1'b1 ||
                    rec_now() !== {4'd3, 4'd3, 10'd320, 11'sd112, 1'b1, 1'b0, 2'b00}) begin
        errors++;
        $display("FAIL hold_bad%0d got st=%0d v=%b ctr=%0d want 3 1 320", i, trk_state,
                 trk_valid, trk_center); end
    end
    send(4'd3, 4'd3, 10'd260, 10'd380);
    checks++; if (trk_state !== 2'd2 || trk_valid !== 1'b1) begin errors++;
      $display("FAIL hold_recover got st=%0d v=%b want 2 1", trk_state, trk_valid); end
    for (int i = 0; i < 7; i++) begin
      send(4'd0, 4'd0, 10'd0, 10'd0);
      checks++; if (trk_state !== 2'd3 || trk_valid !== 1'b1) begin errors++;
        $display("FAIL hold_miss%0d got st=%0d v=%b want 3 1", i + 1, trk_state, trk_valid); end
    end
    send(4'd0, 4'd0, 10'd0, 10'd0);
    checks++; if (trk_state !== 2'd0 || trk_valid !== 1'b0) begin errors++;
      $display("FAIL hold_lost got st=%0d v=%b want 0 0", trk_state, trk_valid); end
    send(4'd0, 4'd0, 10'd0, 10'd0);
    checks++; if (trk_state !== 2'd0 || trk_valid !== 1'b0) begin errors++;
      $display("FAIL hold_after got st=%0d v=%b want 0 0", trk_state, trk_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    trk_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(4'd3, 4'd2, 10'd150, 10'd260);
    checks++; if (trk_valid !== 1'b1 || trk_overrun !== 1'b0 || trk_center !== 10'd205) begin
      errors++;
      $display("FAIL bp_first got v=%b o=%b ctr=%0d want 1 0 205", trk_valid, trk_overrun,
               trk_center); end
    send(4'd3, 4'd2, 10'd160, 10'd280);
    checks++; if (trk_valid !== 1'b1 || trk_overrun !== 1'b1 ||
                  rec_now() !== {4'd3, 4'd2, 10'd220, 11'sd12, 1'b0, 1'b0, 2'b00}) begin
      errors++;
      $display("FAIL bp_overwrite got v=%b o=%b ctr=%0d off=%0d want 1 1 220 12", trk_valid,
               trk_overrun, trk_center, trk_offset); end
    @(negedge clk);
    checks++; if (trk_valid !== 1'b1 || trk_center !== 10'd220) begin errors++;
      $display("FAIL bp_stable got v=%b ctr=%0d want 1 220", trk_valid, trk_center); end
    trk_ready = 1'b1;
    send(4'd3, 4'd2, 10'd150, 10'd260);
    checks++; if (trk_valid !== 1'b1 || trk_center !== 10'd205 || trk_overrun !== 1'b1) begin
      errors++;
      $display("FAIL bp_load_ready got v=%b ctr=%0d o=%b want 1 205 1", trk_valid, trk_center,
               trk_overrun); end
    @(negedge clk);
    checks++; if (trk_valid !== 1'b0) begin errors++;
      $display("FAIL bp_drain got v=%b want 0", trk_valid); end
  endtask

  task automatic test_implausible();
    logic [27:0] vec [5];
    vec[0] = {4'd3, 4'd0, 10'd100, 10'd200};
    vec[1] = {4'd2, 4'd3, 10'd100, 10'd200};
    vec[2] = {4'd3, 4'd2, 10'd200, 10'd200};
    vec[3] = {4'd3, 4'd2, 10'd100, 10'd416};
    vec[4] = {4'd0, 4'd0, 10'd100, 10'd200};
    do_reset();
    trk_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(vec[i][27:24], vec[i][23:20], vec[i][19:10], vec[i][9:0]);
      checks++; if (trk_state !== 2'd0 || trk_valid !== 1'b0) begin errors++;
        $display("FAIL implaus%0d got st=%0d v=%b want 0 0", i, trk_state, trk_valid); end
    end
    send(4'd3, 4'd2, 10'd100, 10'd415);
    checks++; if (trk_state !== 2'd1) begin errors++;
      $display("FAIL edge_right415 got st=%0d want 1", trk_state); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    trk_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(4'd3, 4'd2, 10'd150, 10'd260);
    send(4'd4, 4'd1, 10'd50, 10'd150);
    checks++; if (trk_state !== 2'd1 || trk_valid !== 1'b1 || trk_overrun !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst got st=%0d v=%b o=%b want 1 1 1", trk_state, trk_valid,
               trk_overrun); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (trk_state !== 2'd0 || trk_valid !== 1'b0 || trk_overrun !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got st=%0d v=%b o=%b want 0 0 0", trk_state, trk_valid,
               trk_overrun); end
    trk_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_confirm();
    test_lane_change();
    test_hold();
    test_backpressure();
    test_implausible();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
